xmw_datapath: RTL and testbench
===============================

# xmw_datapath

Parametrised X/M/W pipeline datapath for the in-order core. It registers decoded operands into the execute stage and forwards in-flight results from X, M and W back into those operands. It carries per-stage valid, destination-register and write-enable state down to a write-back port. It sits between decode/register-file read and the register-file write port, and supports global hold, X-stage flush and hazard bubbles.

## Interface
- `XLEN`, 32: datapath width.
- `RAW`, 5: register address width.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset; asynchronous, active-low.
- `d_valid_i` in 1: decode presents an instruction.
- `d_ready_o` out 1: X accepts the decode instruction this cycle.
- `d_rs1_i`, `d_rs2_i`, `d_rd_i` in RAW: source and destination register addresses.
- `d_we_i` in 1: instruction writes `rd`.
- `reg1_data_i`, `reg2_data_i` in XLEN: register-file read data.
- `pc_val_d2_i` in XLEN: PC of the decode instruction.
- `imm_signed_i` in XLEN: sign-extended immediate.
- `d_op1_sel_i`, `d_arith_op1_sel_i` in 1: 0 = REG1, 1 = PC.
- `d_op2_sel_i`, `d_arith_op2_sel_i` in 1: 0 = REG2, 1 = IMM.
- `d_alu_sel_i` in 3: 0 = ARITH, 1 = LOGIC, 2 = SHIFT, 3 = X_OP1, 4 = PC; 5–7 behave as ARITH.
- `arith_out_i`, `logical_out_i`, `shift_out_i` in XLEN: combinational ALU results computed from the X operands.
- `hold_i` in 1: freeze the whole pipeline.
- `flush_i` in 1: kill the instruction entering X.
- `x_op1_o`, `x_op2_o`, `x_arith_op1_o`, `x_arith_op2_o` out XLEN: X-stage operands.
- `m_alu_data_o` out XLEN: M-stage result.
- `w_data_o` out XLEN, `w_rd_o` out RAW, `w_we_o` out 1: register-file write port.
- `hazard_o` out 1: an unresolved RAW dependency exists; X takes a bubble.

## Operation
- **Stage registers**
  - X holds: valid, rd, we, alu_sel, pc, and four operands.
  - M holds: valid, rd, we, data.
  - W holds: valid, rd, we, data.
  - All registers reset to 0.
- **Accept.** `d_ready_o = !hold_i && !hazard_o`. X captures the decode instruction when `d_ready_o && d_valid_i && !flush_i`.
- **Bubble.** X valid is cleared if any of these holds: `d_valid_i` = 0, `hazard_o` = 1, or `flush_i` = 1. A bubble never writes.
- **Hold.**
  - While `hold_i` = 1, all stage registers keep their values.
  - Exception: when `flush_i` = 1 in the same cycle, X valid clears. Flush wins over hold for X valid only.
- **Advance.**
  - X→M data is the result selected by `x_alu_sel`: ARITH, LOGIC, SHIFT, x_op1, or x_pc.
  - M→W copies the M stage.
  - `w_we_o = w_valid && w_we && w_rd != 0`.
- **Operand select.** When the select is REG, the source value is the register-file data, replaced by a forward when one is enabled. PC and IMM selects are never forwarded. The `arith` operand muxes use their own selects but share the same forward logic.
- **Producer match.** A stage matches a source address rs when: stage valid, stage we, stage rd == rs, and rs != 0.
- **Forwarding priority** (DATAPATH_FWD_EN only): X (the ALU result about to enter M) over M data over W data over register-file data.
- **hazard_o** is combinational and only asserts when `d_valid_i` = 1.
  - With forwarding: always 0.
  - Without forwarding: 1 if either source used by a REG select matches X, M, or W.
- **Width.** All data passes unmodified at XLEN. There is no arithmetic inside the block.

## Timing
- **Latency.** An instruction accepted at edge n appears:
  - at the X outputs after edge n;
  - at `m_alu_data_o` after edge n+1;
  - at the W outputs after edge n+2.
  - `w_we_o` is high for one cycle unless `hold_i` stretches it.
- **Throughput.** One instruction per cycle with forwarding. Without forwarding, a dependent back-to-back pair costs 3 bubble cycles.
- **Reset.**
  - Asynchronous assertion clears every register immediately.
  - All outputs are 0, except `d_ready_o`, which equals `!hold_i && !hazard_o` combinationally (1 with quiet inputs).
  - In-flight instructions are dropped; no write occurs after reset.
- **Simultaneous events.** When hazard and flush occur together, X takes a bubble. Hold combined with a hazard stalls the pipeline and decode.
- **Output stability.** All outputs except `d_ready_o` and `hazard_o` are registered.

## Configuration
- `DATAPATH_FWD_EN` defined: the X/M/W forwarding network is built and `hazard_o` is tied to 0.
- Undefined: no forward muxes. Operands come only from the register file, and `hazard_o` and the bubble insertion described above are active.
- The port list is identical in both builds.

## Test plan
- **Forwarding, chained.** Issue `x1=5+7` (ARITH, `arith_out_i`=12), then `x2=x1+imm 3` on the next cycle. Required: `x_arith_op1_o`=12 from the X forward, `w_data_o`=12 then 15, with no bubble.
- **No forwarding.** Run the same sequence with the macro undefined. Required: `hazard_o`=1 and `d_ready_o`=0 for 3 cycles, then the second instruction reads `reg1_data_i`.
- **x0 destination.** Write rd=0 with data 0xDEAD, then read rs1=0. Required: `w_we_o`=0, no forward, `reg1_data_i` passed through.
- **Hold.** Assert `hold_i` for 2 cycles with 3 instructions in flight. Required: X, M and W values frozen, `w_we_o` held, and the sequence resumes intact.
- **Flush.** Assert `flush_i` together with `hold_i` while X is valid. Required: X valid=0 and that instruction never reaches `w_we_o`; M and W are unaffected.
- **Reset mid-flight.** Assert `rst_n_i` low between clock edges with all stages valid. Required: all registered outputs 0 immediately and no `w_we_o` after release.

Source files
------------

// File: rtl/xmw_datapath_if.sv
// Decode-side and write-back-side signal bundle for xmw_datapath.
// master drives decode/ALU/control; slave is the datapath itself.
interface xmw_datapath_if #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
);
   logic            d_valid_i;
   logic            d_ready_o;
   logic [RAW-1:0]  d_rs1_i;
   logic [RAW-1:0]  d_rs2_i;
   logic [RAW-1:0]  d_rd_i;
   logic            d_we_i;
   logic [XLEN-1:0] reg1_data_i;
   logic [XLEN-1:0] reg2_data_i;
   logic [XLEN-1:0] pc_val_d2_i;
   logic [XLEN-1:0] imm_signed_i;
   logic            d_op1_sel_i;
   logic            d_arith_op1_sel_i;
   logic            d_op2_sel_i;
   logic            d_arith_op2_sel_i;
   logic [2:0]      d_alu_sel_i;
   logic [XLEN-1:0] arith_out_i;
   logic [XLEN-1:0] logical_out_i;
   logic [XLEN-1:0] shift_out_i;
   logic            hold_i;
   logic            flush_i;
   logic [XLEN-1:0] x_op1_o;
   logic [XLEN-1:0] x_op2_o;
   logic [XLEN-1:0] x_arith_op1_o;
   logic [XLEN-1:0] x_arith_op2_o;
   logic [XLEN-1:0] m_alu_data_o;
   logic [XLEN-1:0] w_data_o;
   logic [RAW-1:0]  w_rd_o;
   logic            w_we_o;
   logic            hazard_o;

   modport master (
      output d_valid_i, d_rs1_i, d_rs2_i, d_rd_i, d_we_i,
      output reg1_data_i, reg2_data_i, pc_val_d2_i, imm_signed_i,
      output d_op1_sel_i, d_arith_op1_sel_i,
      output d_op2_sel_i, d_arith_op2_sel_i, d_alu_sel_i,
      output arith_out_i, logical_out_i, shift_out_i,
      output hold_i, flush_i,
      input  d_ready_o, x_op1_o, x_op2_o,
      input  x_arith_op1_o, x_arith_op2_o, m_alu_data_o,
      input  w_data_o, w_rd_o, w_we_o, hazard_o
   );

   modport slave (
      input  d_valid_i, d_rs1_i, d_rs2_i, d_rd_i, d_we_i,
      input  reg1_data_i, reg2_data_i, pc_val_d2_i, imm_signed_i,
      input  d_op1_sel_i, d_arith_op1_sel_i,
      input  d_op2_sel_i, d_arith_op2_sel_i, d_alu_sel_i,
      input  arith_out_i, logical_out_i, shift_out_i,
      input  hold_i, flush_i,
      output d_ready_o, x_op1_o, x_op2_o,
      output x_arith_op1_o, x_arith_op2_o, m_alu_data_o,
      output w_data_o, w_rd_o, w_we_o, hazard_o
   );
endinterface

// File: rtl/xmw_datapath.sv
// X/M/W pipeline datapath: operand capture, forwarding, write-back port.
// Define DATAPATH_FWD_EN to build forwarding; otherwise RAW hazards stall.
module xmw_datapath #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input logic           clk_i,
   input logic           rst_n_i,
   xmw_datapath_if.slave bus
);

   logic            x_valid, x_we;
   logic [RAW-1:0]  x_rd;
   logic [2:0]      x_alu_sel;
   logic [XLEN-1:0] x_pc, x_op1, x_op2, x_aop1, x_aop2;

   logic            m_valid, m_we;
   logic [RAW-1:0]  m_rd;
   logic [XLEN-1:0] m_data;

   logic            w_valid, w_we;
   logic [RAW-1:0]  w_rd;
   logic [XLEN-1:0] w_data;

   logic [XLEN-1:0] x_result;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [XLEN-1:0] op1_nxt, op2_nxt, aop1_nxt, aop2_nxt;
   logic            hazard, ready, accept;

   function automatic logic hit(
      input logic           v,
      input logic           we,
      input logic [RAW-1:0] rd,
      input logic [RAW-1:0] rs
   );
      return v && we && (rd == rs) && (rs != '0);
   endfunction

   always_comb begin
      x_result = bus.arith_out_i;
      unique case (x_alu_sel)
         3'd1:    x_result = bus.logical_out_i;
         3'd2:    x_result = bus.shift_out_i;
         3'd3:    x_result = x_op1;
         3'd4:    x_result = x_pc;
         default: x_result = bus.arith_out_i;
      endcase
   end

`ifdef DATAPATH_FWD_EN
   // Youngest producer wins: X result, then M, then W, then regfile.
   always_comb begin
      rs1_val = bus.reg1_data_i;
      if (hit(x_valid, x_we, x_rd, bus.d_rs1_i))
         rs1_val = x_result;
      else if (hit(m_valid, m_we, m_rd, bus.d_rs1_i))
         rs1_val = m_data;
      else if (hit(w_valid, w_we, w_rd, bus.d_rs1_i))
         rs1_val = w_data;

      rs2_val = bus.reg2_data_i;
      if (hit(x_valid, x_we, x_rd, bus.d_rs2_i))
         rs2_val = x_result;
      else if (hit(m_valid, m_we, m_rd, bus.d_rs2_i))
         rs2_val = m_data;
      else if (hit(w_valid, w_we, w_rd, bus.d_rs2_i))
         rs2_val = w_data;
   end

   assign hazard = 1'b0;
`else
   logic use1, use2, dep1, dep2;

   assign rs1_val = bus.reg1_data_i;
   assign rs2_val = bus.reg2_data_i;

   assign use1 = !bus.d_op1_sel_i || !bus.d_arith_op1_sel_i;
   assign use2 = !bus.d_op2_sel_i || !bus.d_arith_op2_sel_i;

   assign dep1 = hit(x_valid, x_we, x_rd, bus.d_rs1_i)
              || hit(m_valid, m_we, m_rd, bus.d_rs1_i)
              || hit(w_valid, w_we, w_rd, bus.d_rs1_i);
   assign dep2 = hit(x_valid, x_we, x_rd, bus.d_rs2_i)
              || hit(m_valid, m_we, m_rd, bus.d_rs2_i)
              || hit(w_valid, w_we, w_rd, bus.d_rs2_i);

   assign hazard = bus.d_valid_i
                && ((use1 && dep1) || (use2 && dep2));
`endif

   assign op1_nxt  = bus.d_op1_sel_i       ? bus.pc_val_d2_i  : rs1_val;
   assign aop1_nxt = bus.d_arith_op1_sel_i ? bus.pc_val_d2_i  : rs1_val;
   assign op2_nxt  = bus.d_op2_sel_i       ? bus.imm_signed_i : rs2_val;
   assign aop2_nxt = bus.d_arith_op2_sel_i ? bus.imm_signed_i : rs2_val;

   assign ready  = !bus.hold_i && !hazard;
   assign accept = ready && bus.d_valid_i && !bus.flush_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         x_valid   <= 1'b0;
         x_we      <= 1'b0;
         x_rd      <= '0;
         x_alu_sel <= '0;
         x_pc      <= '0;
         x_op1     <= '0;
         x_op2     <= '0;
         x_aop1    <= '0;
         x_aop2    <= '0;
      end else if (!bus.hold_i) begin
         x_valid <= accept;
         if (accept) begin
            x_we      <= bus.d_we_i;
            x_rd      <= bus.d_rd_i;
            x_alu_sel <= bus.d_alu_sel_i;
            x_pc      <= bus.pc_val_d2_i;
            x_op1     <= op1_nxt;
            x_op2     <= op2_nxt;
            x_aop1    <= aop1_nxt;
            x_aop2    <= aop2_nxt;
         end
      end else if (bus.flush_i) begin
         // a flush still kills X while everything else is frozen
         x_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m_valid <= 1'b0;
         m_we    <= 1'b0;
         m_rd    <= '0;
         m_data  <= '0;
         w_valid <= 1'b0;
         w_we    <= 1'b0;
         w_rd    <= '0;
         w_data  <= '0;
      end else if (!bus.hold_i) begin
         m_valid <= x_valid;
         m_we    <= x_we;
         m_rd    <= x_rd;
         m_data  <= x_result;
         w_valid <= m_valid;
         w_we    <= m_we;
         w_rd    <= m_rd;
         w_data  <= m_data;
      end
   end

   assign bus.d_ready_o     = ready;
   assign bus.hazard_o      = hazard;
   assign bus.x_op1_o       = x_op1;
   assign bus.x_op2_o       = x_op2;
   assign bus.x_arith_op1_o = x_aop1;
   assign bus.x_arith_op2_o = x_aop2;
   assign bus.m_alu_data_o  = m_data;
   assign bus.w_data_o      = w_data;
   assign bus.w_rd_o        = w_rd;
   assign bus.w_we_o        = w_valid && w_we && (w_rd != '0);

endmodule

// File: tb/tb_xmw_datapath.sv
// Directed bench for xmw_datapath: vector table plus pipeline sequences.
// Expectations adapt to DATAPATH_FWD_EN where forwarding changes timing.
module tb_xmw_datapath;
   localparam int XLEN = 32;
   localparam int RAW  = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xmw_datapath_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

   xmw_datapath #(.XLEN(XLEN), .RAW(RAW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic        we;
      logic [31:0] reg1, reg2, pc, imm;
      logic        s1, s2, as1, as2;
      logic [2:0]  alu;
      logic [31:0] ar, lg, sh;
      logic [31:0] e_op1, e_op2, e_aop1, e_aop2, e_m;
      logic        e_we;
   } vec_t;

   vec_t tbl[8];
   int n_vec = 0;
   int n_err = 0;
   logic [36:0] wlog[$];

   // every committed write, one entry per cycle w_we_o is high
   always @(negedge clk)
      if (bus.w_we_o) wlog.push_back({bus.w_rd_o, bus.w_data_o});

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [36:0] wat(input int i);
      if (i < wlog.size()) return wlog[i];
      return '1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.d_valid_i         = 1'b0;
      bus.d_rs1_i           = '0;
      bus.d_rs2_i           = '0;
      bus.d_rd_i            = '0;
      bus.d_we_i            = 1'b0;
      bus.reg1_data_i       = '0;
      bus.reg2_data_i       = '0;
      bus.pc_val_d2_i       = '0;
      bus.imm_signed_i      = '0;
      bus.d_op1_sel_i       = 1'b0;
      bus.d_arith_op1_sel_i = 1'b0;
      bus.d_op2_sel_i       = 1'b0;
      bus.d_arith_op2_sel_i = 1'b0;
      bus.d_alu_sel_i       = '0;
      bus.arith_out_i       = '0;
      bus.logical_out_i     = '0;
      bus.shift_out_i       = '0;
      bus.hold_i            = 1'b0;
      bus.flush_i           = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      bus.d_valid_i         = 1'b1;
      bus.d_rs1_i           = v.rs1;
      bus.d_rs2_i           = v.rs2;
      bus.d_rd_i            = v.rd;
      bus.d_we_i            = v.we;
      bus.reg1_data_i       = v.reg1;
      bus.reg2_data_i       = v.reg2;
      bus.pc_val_d2_i       = v.pc;
      bus.imm_signed_i      = v.imm;
      bus.d_op1_sel_i       = v.s1;
      bus.d_op2_sel_i       = v.s2;
      bus.d_arith_op1_sel_i = v.as1;
      bus.d_arith_op2_sel_i = v.as2;
      bus.d_alu_sel_i       = v.alu;
      bus.arith_out_i       = v.ar;
      bus.logical_out_i     = v.lg;
      bus.shift_out_i       = v.sh;
   endtask

   // register-register ARITH instruction, all selects REG
   task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] r1,
                      input logic [31:0] r2);
      bus.d_valid_i         = 1'b1;
      bus.d_rs1_i           = rs1;
      bus.d_rs2_i           = rs2;
      bus.d_rd_i            = rd;
      bus.d_we_i            = 1'b1;
      bus.reg1_data_i       = r1;
      bus.reg2_data_i       = r2;
      bus.d_op1_sel_i       = 1'b0;
      bus.d_op2_sel_i       = 1'b0;
      bus.d_arith_op1_sel_i = 1'b0;
      bus.d_arith_op2_sel_i = 1'b0;
      bus.d_alu_sel_i       = 3'd0;
   endtask

   initial begin
      int hz;
      int guard;
      logic [31:0] r1_chain;

      tbl[0] = '{5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22, 32'h100, 32'h20,
                 1'b0, 1'b1, 1'b1, 1'b0, 3'd0,
                 32'hAAAA, 32'hBBBB, 32'hCCCC,
                 32'h11, 32'h20, 32'h100, 32'h22, 32'hAAAA, 1'b1};
      tbl[1] = '{5'd4, 5'd5, 5'd6, 1'b1, 32'h1111_0000, 32'h2222_0000,
                 32'h8000_0004, 32'hFFFF_FFF0,
                 1'b1, 1'b0, 1'b0, 1'b1, 3'd1,
                 32'h1, 32'h0F0F_0F0F, 32'h3,
                 32'h8000_0004, 32'h2222_0000, 32'h1111_0000,
                 32'hFFFF_FFF0, 32'h0F0F_0F0F, 1'b1};
      tbl[2] = '{5'd7, 5'd8, 5'd9, 1'b1, 32'h123, 32'h456, 32'h200, 32'h4,
                 1'b0, 1'b0, 1'b0, 1'b0, 3'd2,
                 32'h1, 32'h2, 32'h8000_0000,
                 32'h123, 32'h456, 32'h123, 32'h456, 32'h8000_0000, 1'b1};
      tbl[3] = '{5'd10, 5'd11, 5'd12, 1'b1, 32'h33, 32'h44, 32'h300, 32'h8,
                 1'b1, 1'b1, 1'b0, 1'b0, 3'd3,
                 32'h1, 32'h2, 32'h3,
                 32'h300, 32'h8, 32'h33, 32'h44, 32'h300, 1'b1};
      tbl[4] = '{5'd13, 5'd14, 5'd15, 1'b1, 32'h55, 32'h66, 32'h400, 32'hC,
                 1'b0, 1'b0, 1'b0, 1'b0, 3'd4,
                 32'h1, 32'h2, 32'h3,
                 32'h55, 32'h66, 32'h55, 32'h66, 32'h400, 1'b1};
      tbl[5] = '{5'd16, 5'd17, 5'd31, 1'b1, 32'h77, 32'h88, 32'h500, 32'h10,
                 1'b0, 1'b0, 1'b1, 1'b1, 3'd7,
                 32'hFEED_BEEF, 32'h2, 32'h3,
                 32'h77, 32'h88, 32'h500, 32'h10, 32'hFEED_BEEF, 1'b1};
      tbl[6] = '{5'd18, 5'd19, 5'd20, 1'b0, 32'h99, 32'hAA, 32'h600, 32'h14,
                 1'b0, 1'b0, 1'b0, 1'b0, 3'd0,
                 32'h1234_5678, 32'h2, 32'h3,
                 32'h99, 32'hAA, 32'h99, 32'hAA, 32'h1234_5678, 1'b0};
      tbl[7] = '{5'd21, 5'd22, 5'd0, 1'b1, 32'hBB, 32'hCC, 32'h700, 32'h18,
                 1'b0, 1'b0, 1'b0, 1'b0, 3'd0,
                 32'hDEAD, 32'h2, 32'h3,
                 32'hBB, 32'hCC, 32'hBB, 32'hCC, 32'hDEAD, 1'b0};

      // reset state
      quiet();
      #2;
      chk("rst_x_op1", 64'(bus.x_op1_o), 64'h0);
      chk("rst_m", 64'(bus.m_alu_data_o), 64'h0);
      chk("rst_w_we", 64'(bus.w_we_o), 64'h0);
      chk("rst_ready", 64'(bus.d_ready_o), 64'h1);
      chk("rst_hazard", 64'(bus.hazard_o), 64'h0);
      #10 rst_n = 1'b1;
      tick();

      // single instructions through an empty pipeline
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d_ready", i), 64'(bus.d_ready_o), 64'h1);
         tick();
         bus.d_valid_i = 1'b0;
         chk($sformatf("v%0d_op1", i), 64'(bus.x_op1_o), 64'(tbl[i].e_op1));
         chk($sformatf("v%0d_op2", i), 64'(bus.x_op2_o), 64'(tbl[i].e_op2));
         chk($sformatf("v%0d_aop1", i), 64'(bus.x_arith_op1_o),
             64'(tbl[i].e_aop1));
         chk($sformatf("v%0d_aop2", i), 64'(bus.x_arith_op2_o),
             64'(tbl[i].e_aop2));
         tick();
         chk($sformatf("v%0d_m", i), 64'(bus.m_alu_data_o), 64'(tbl[i].e_m));
         tick();
         chk($sformatf("v%0d_wd", i), 64'(bus.w_data_o), 64'(tbl[i].e_m));
         chk($sformatf("v%0d_wrd", i), 64'(bus.w_rd_o), 64'(tbl[i].rd));
         chk($sformatf("v%0d_wwe", i), 64'(bus.w_we_o), 64'(tbl[i].e_we));
         tick();
      end

      // chained dependency: x1 = 5+7, then x2 = x1 + 3
      quiet();
      wlog.delete();
      ins(5'd2, 5'd3, 5'd1, 32'd5, 32'd7);
      bus.arith_out_i = 32'd12;
      tick();
`ifdef DATAPATH_FWD_EN
      r1_chain = 32'h99;
`else
      r1_chain = 32'd12;
`endif
      ins(5'd1, 5'd9, 5'd2, r1_chain, 32'h0);
      bus.d_op2_sel_i       = 1'b1;
      bus.d_arith_op2_sel_i = 1'b1;
      bus.imm_signed_i      = 32'd3;
      #1;
      hz = 0;
      guard = 0;
      while (bus.hazard_o && guard < 8) begin
         hz++;
         chk("stall_ready", 64'(bus.d_ready_o), 64'h0);
         tick();
         bus.arith_out_i = 32'd15;
         #1;
         guard++;
      end
`ifdef DATAPATH_FWD_EN
      chk("chain_bubbles", 64'(hz), 64'd0);
`else
      chk("chain_bubbles", 64'(hz), 64'd3);
`endif
      tick();
      bus.d_valid_i   = 1'b0;
      bus.arith_out_i = 32'd15;
      chk("chain_aop1", 64'(bus.x_arith_op1_o), 64'd12);
      chk("chain_op1", 64'(bus.x_op1_o), 64'd12);
      chk("chain_aop2", 64'(bus.x_arith_op2_o), 64'd3);
      repeat (4) tick();
      chk("chain_nwr", 64'(wlog.size()), 64'd2);
      chk("chain_w0", 64'(wat(0)), 64'({5'd1, 32'd12}));
      chk("chain_w1", 64'(wat(1)), 64'({5'd2, 32'd15}));

      // x0 destination is neither written nor forwarded
      quiet();
      wlog.delete();
      ins(5'd3, 5'd4, 5'd0, 32'h1, 32'h2);
      bus.arith_out_i = 32'hDEAD;
      tick();
      ins(5'd0, 5'd0, 5'd9, 32'h1234, 32'h5678);
      bus.d_we_i = 1'b0;
      #1;
      chk("x0_hazard", 64'(bus.hazard_o), 64'h0);
      tick();
      bus.d_valid_i = 1'b0;
      chk("x0_op1", 64'(bus.x_op1_o), 64'h1234);
      chk("x0_aop1", 64'(bus.x_arith_op1_o), 64'h1234);
      chk("x0_op2", 64'(bus.x_op2_o), 64'h5678);
      repeat (4) tick();
      chk("x0_nwr", 64'(wlog.size()), 64'd0);

      // hold for two cycles with X, M and W all occupied
      quiet();
      wlog.delete();
      ins(5'd10, 5'd11, 5'd4, 32'hA0, 32'h0);
      tick();
      ins(5'd10, 5'd11, 5'd5, 32'hB0, 32'h0);
      bus.arith_out_i = 32'hA1;
      tick();
      ins(5'd10, 5'd11, 5'd6, 32'hC0, 32'h0);
      bus.arith_out_i = 32'hB2;
      tick();
      bus.d_valid_i   = 1'b0;
      bus.arith_out_i = 32'hC3;
      bus.hold_i      = 1'b1;
      #1;
      chk("hold_ready", 64'(bus.d_ready_o), 64'h0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk($sformatf("hold%0d_x", c), 64'(bus.x_op1_o), 64'hC0);
         chk($sformatf("hold%0d_m", c), 64'(bus.m_alu_data_o), 64'hB2);
         chk($sformatf("hold%0d_w", c), 64'(bus.w_data_o), 64'hA1);
         chk($sformatf("hold%0d_we", c), 64'(bus.w_we_o), 64'h1);
      end
      bus.hold_i = 1'b0;
      repeat (4) tick();
      chk("hold_nwr", 64'(wlog.size()), 64'd5);
      chk("hold_w0", 64'(wat(0)), 64'({5'd4, 32'hA1}));
      chk("hold_w2", 64'(wat(2)), 64'({5'd4, 32'hA1}));
      chk("hold_w3", 64'(wat(3)), 64'({5'd5, 32'hB2}));
      chk("hold_w4", 64'(wat(4)), 64'({5'd6, 32'hC3}));

      // flush together with hold kills only the X instruction
      quiet();
      wlog.delete();
      ins(5'd12, 5'd13, 5'd7, 32'h1, 32'h2);
      tick();
      ins(5'd12, 5'd13, 5'd8, 32'h3, 32'h4);
      bus.arith_out_i = 32'h77;
      tick();
      bus.d_valid_i   = 1'b0;
      bus.arith_out_i = 32'h88;
      bus.hold_i      = 1'b1;
      bus.flush_i     = 1'b1;
      tick();
      bus.hold_i  = 1'b0;
      bus.flush_i = 1'b0;
      chk("flush_m", 64'(bus.m_alu_data_o), 64'h77);
      chk("flush_w_we", 64'(bus.w_we_o), 64'h0);
      repeat (4) tick();
      chk("flush_nwr", 64'(wlog.size()), 64'd1);
      chk("flush_w0", 64'(wat(0)), 64'({5'd7, 32'h77}));

      // asynchronous reset with every stage valid
      quiet();
      ins(5'd20, 5'd21, 5'd1, 32'h101, 32'h202);
      tick();
      ins(5'd20, 5'd21, 5'd2, 32'h303, 32'h404);
      bus.arith_out_i = 32'h5A5A;
      tick();
      ins(5'd20, 5'd21, 5'd3, 32'h505, 32'h606);
      bus.arith_out_i = 32'h6B6B;
      tick();
      quiet();
      bus.arith_out_i = 32'h7C7C;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_op1", 64'(bus.x_op1_o), 64'h0);
      chk("arst_op2", 64'(bus.x_op2_o), 64'h0);
      chk("arst_aop1", 64'(bus.x_arith_op1_o), 64'h0);
      chk("arst_aop2", 64'(bus.x_arith_op2_o), 64'h0);
      chk("arst_m", 64'(bus.m_alu_data_o), 64'h0);
      chk("arst_wd", 64'(bus.w_data_o), 64'h0);
      chk("arst_wrd", 64'(bus.w_rd_o), 64'h0);
      chk("arst_we", 64'(bus.w_we_o), 64'h0);
      chk("arst_ready", 64'(bus.d_ready_o), 64'h1);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      wlog.delete();
      repeat (5) tick();
      chk("arst_nwr", 64'(wlog.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
